// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: decode-stage immediate generator with a DEPTH-entry output
// FIFO. The immediate is formed combinationally at the input and stored on push.
// Each entry carries a sideband tag and an illegal-format flag. A saturating
// counter tracks how many illegal encodings have been accepted.
module imm_extend_pipe #(
   parameter int XLEN       = 32,
   parameter int DEPTH      = 2,
   parameter int TAG_W      = 8,
   parameter bit U_PRESHIFT = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_immsrc,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_immext,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err,
   output logic [15:0]      err_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [CW-1:0]    count;
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [XLEN-1:0]  imm_mem [DEPTH];
   logic [TAG_W-1:0] tag_mem [DEPTH];
   logic             err_mem [DEPTH];

   logic [31:0]      imm32;
   logic             imm_err;
   logic [XLEN-1:0]  imm_x;
   logic             push, pop;

   // opcode bits never feed any immediate format
   logic unused_opcode;
   assign unused_opcode = ^in_instr[6:0];

   // Every format fits in 32 bits already sign/zero-extended to 32; widening to
   // XLEN is then a plain sign extension (zero-extended formats have bit 31 = 0).
   always_comb begin
      imm32   = '0;
      imm_err = 1'b0;
      case (in_immsrc)
         3'b000: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         3'b001: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         3'b010: imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
         3'b011: imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
         3'b100: imm32 = U_PRESHIFT ? {in_instr[31:12], 12'b0}
                                    : {{12{in_instr[31]}}, in_instr[31:12]};
         3'b101: imm32 = {27'b0, in_instr[19:15]};
         3'b110: imm32 = (XLEN == 64) ? {26'b0, in_instr[25:20]}
                                      : {27'b0, in_instr[24:20]};
         default: begin
            imm32   = '0;
            imm_err = 1'b1;
         end
      endcase
   end

   assign imm_x = XLEN'($signed(imm32));

   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   // Head entry; forced to zero while empty so reset values are clean
   assign out_immext = out_valid ? imm_mem[rd_ptr] : '0;
   assign out_tag    = out_valid ? tag_mem[rd_ptr] : '0;
   assign out_err    = out_valid ? err_mem[rd_ptr] : 1'b0;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // FIFO control: occupancy, pointers; flush wins over push/pop
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage; contents are only observed through the valid-gated outputs
   always_ff @(posedge clk) begin
      if (push) begin
         imm_mem[wr_ptr] <= imm_x;
         tag_mem[wr_ptr] <= in_tag;
         err_mem[wr_ptr] <= imm_err;
      end
   end

   // Illegal-encoding counter: counts on accept, saturates, ignores flush
   always_ff @(posedge clk) begin
      if (reset)
         err_count <= '0;
      else if (push && imm_err && err_count != 16'hFFFF)
         err_count <= err_count + 1'b1;
   end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: instance a (XLEN=32, DEPTH=2, U preshift) is
// tracked every cycle against a queue-based model; instance b (XLEN=64,
// DEPTH=4, legacy U) gets directed vectors.
module tb_imm_extend_pipe;

   logic clk = 1'b0, reset = 1'b1, flush = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_instr = '0;
   logic [2:0]  in_immsrc = '0;
   logic [7:0]  in_tag = '0;
   logic        in_ready, out_valid, out_err;
   logic [31:0] out_immext;
   logic [7:0]  out_tag;
   logic [15:0] err_count;

   logic        b_in_valid = 1'b0, b_out_ready = 1'b0;
   logic [31:0] b_in_instr = '0;
   logic [2:0]  b_in_immsrc = '0;
   logic [7:0]  b_in_tag = '0;
   logic        b_in_ready, b_out_valid, b_out_err;
   logic [63:0] b_out_immext;
   logic [7:0]  b_out_tag;
   logic [15:0] b_err_count;

   imm_extend_pipe #(.XLEN(32), .DEPTH(2), .TAG_W(8), .U_PRESHIFT(1'b1)) u_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_immsrc(in_immsrc), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_immext(out_immext),
      .out_tag(out_tag), .out_err(out_err), .err_count(err_count));

   imm_extend_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(8), .U_PRESHIFT(1'b0)) u_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
      .in_immsrc(b_in_immsrc), .in_tag(b_in_tag),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_immext(b_out_immext),
      .out_tag(b_out_tag), .out_err(b_out_err), .err_count(b_err_count));

   int n_chk = 0, n_fail = 0;
   bit started = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // signed value of a w-bit field
   function automatic longint sx(input longint f, input int w);
      return (f >= (longint'(1) << (w - 1))) ? f - (longint'(1) << w) : f;
   endfunction

   // reference immediate from the format table, masked to xlen
   function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s,
                                           input int xlen, input bit upre);
      longint v;
      case (s)
         3'd0: v = sx(longint'(i[31:20]), 12);
         3'd1: v = sx(longint'({i[31:25], i[11:7]}), 12);
         3'd2: v = sx(longint'({i[31], i[7], i[30:25], i[11:8]}), 12) * 2;
         3'd3: v = sx(longint'({i[31], i[19:12], i[20], i[30:21]}), 20) * 2;
         3'd4: v = upre ? sx(longint'(i[31:12]), 20) * 4096 : sx(longint'(i[31:12]), 20);
         3'd5: v = longint'(i[19:15]);
         3'd6: v = (xlen == 64) ? longint'(i[25:20]) : longint'(i[24:20]);
         default: v = 0;
      endcase
      return (xlen == 32) ? (v & 64'h0000_0000_FFFF_FFFF) : v;
   endfunction

   typedef struct { logic [63:0] imm; logic [7:0] tag; logic err; } ent_t;
   ent_t q[$];
   logic [15:0] m_errs = '0;
   bit m_push, m_pop;

   // model of instance a: FIFO as a queue of capacity 2
   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_errs = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         m_push = in_valid && (q.size() < 2);
         m_pop  = out_ready && (q.size() > 0);
         if (m_pop) void'(q.pop_front());
         if (m_push) begin
            q.push_back('{ref_imm(in_instr, in_immsrc, 32, 1'b1), in_tag, in_immsrc == 3'd7});
            if (in_immsrc == 3'd7 && m_errs != 16'hFFFF) m_errs = m_errs + 1'b1;
         end
      end
   end

   // per-cycle compare of instance a against the model
   always @(negedge clk) begin
      if (started) begin
         chk("sb_out_valid", out_valid, q.size() != 0);
         chk("sb_in_ready", in_ready, q.size() != 2);
         chk("sb_err_count", err_count, m_errs);
         if (q.size() != 0) begin
            chk("sb_immext", out_immext, q[0].imm);
            chk("sb_tag", out_tag, q[0].tag);
            chk("sb_err", out_err, q[0].err);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // one entry through a: check visibility after one edge, then drain
   task automatic a_one(input logic [31:0] ins, input logic [2:0] src,
                        input logic [7:0] tg, input logic [31:0] exp, input string nm);
      in_valid = 1'b1; in_instr = ins; in_immsrc = src; in_tag = tg; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      chk({nm, "_valid"}, out_valid, 1'b1);
      chk({nm, "_imm"}, out_immext, exp);
      chk({nm, "_tag"}, out_tag, tg);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({nm, "_drained"}, out_valid, 1'b0);
   endtask

   task automatic b_one(input logic [31:0] ins, input logic [2:0] src,
                        input logic [63:0] exp, input string nm);
      b_in_valid = 1'b1; b_in_instr = ins; b_in_immsrc = src; b_out_ready = 1'b0;
      step();
      b_in_valid = 1'b0;
      chk({nm, "_valid"}, b_out_valid, 1'b1);
      chk({nm, "_imm"}, b_out_immext, exp);
      chk({nm, "_model"}, b_out_immext, ref_imm(ins, src, 64, 1'b0));
      b_out_ready = 1'b1;
      step();
      b_out_ready = 1'b0;
   endtask

   initial begin
      step(); step();
      reset = 1'b0;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ready", in_ready, 1'b1);
      chk("rst_imm", out_immext, 32'h0);
      chk("rst_errcnt", err_count, 16'h0);
      started = 1'b1;

      // format vectors with hand-computed results
      a_one(32'hFFF00093, 3'd0, 8'h11, 32'hFFFFFFFF, "i_type");
      a_one(32'hFE112E23, 3'd1, 8'h12, 32'hFFFFFFFC, "s_type");
      a_one(32'hFF9FF06F, 3'd3, 8'h13, 32'hFFFFFFF8, "j_type");
      a_one(32'h000153B7, 3'd4, 8'h14, 32'h00015000, "u_pre");
      a_one(32'h03F00013, 3'd6, 8'h15, 32'h0000001F, "shamt32");
      a_one(32'h000FD073, 3'd5, 8'h16, 32'h0000001F, "csr_uimm");
      a_one(32'h80000063, 3'd2, 8'h17, 32'hFFFFF000, "b_min");

      // backpressure: tag 3 must be held until space opens
      out_ready = 1'b0; in_instr = 32'h00100093; in_immsrc = 3'd0; in_valid = 1'b1;
      in_tag = 8'd1; step();
      in_tag = 8'd2; step();
      in_tag = 8'd3; step();
      chk("bp_full_ready", in_ready, 1'b0);
      chk("bp_head1", out_tag, 8'd1);
      out_ready = 1'b1; step();
      chk("bp_head2", out_tag, 8'd2);
      step();
      in_valid = 1'b0;
      chk("bp_head3", out_tag, 8'd3);
      step();
      chk("bp_empty", out_valid, 1'b0);
      out_ready = 1'b0;

      // illegal encodings
      a_one(32'h00000013, 3'd7, 8'h20, 32'h0, "illegal");
      chk("ill_errcnt1", err_count, 16'd1);
      out_ready = 1'b1; in_valid = 1'b1; in_immsrc = 3'd7;
      repeat (5) step();
      in_valid = 1'b0; step();
      chk("ill_errcnt6", err_count, 16'd6);
      flush = 1'b1; step(); flush = 1'b0;
      chk("flush_errcnt", err_count, 16'd6);

      // flush with two buffered and an input offered
      out_ready = 1'b0; in_valid = 1'b1; in_immsrc = 3'd0;
      step(); step();
      chk("fl_full", in_ready, 1'b0);
      flush = 1'b1; step();
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_valid", out_valid, 1'b0);
      chk("fl_ready", in_ready, 1'b1);
      step();
      chk("fl_dropped", out_valid, 1'b0);

      // reset mid-stream
      in_valid = 1'b1; in_immsrc = 3'd7; in_tag = 8'h55;
      step(); step();
      in_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
      chk("mrst_valid", out_valid, 1'b0);
      chk("mrst_ready", in_ready, 1'b1);
      chk("mrst_imm", out_immext, 32'h0);
      chk("mrst_tag", out_tag, 8'h0);
      chk("mrst_err", out_err, 1'b0);
      chk("mrst_errcnt", err_count, 16'h0);

      // throughput: one entry per cycle with a ready consumer
      out_ready = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 100; k++) begin
         in_instr = $urandom; in_immsrc = 3'($urandom_range(0, 7)); in_tag = 8'(k);
         step();
         chk("tp_ready", in_ready, 1'b1);
         chk("tp_valid", out_valid, 1'b1);
         chk("tp_tag", out_tag, 8'(k));
      end
      in_valid = 1'b0; step();

      // random valid/ready/flush mix, scoreboard only
      for (int k = 0; k < 300; k++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 19) == 0);
         in_instr = $urandom; in_immsrc = 3'($urandom_range(0, 7)); in_tag = 8'($urandom);
         step();
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; step(); step();

      // XLEN=64, legacy U alignment
      b_one(32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, "b64_i");
      b_one(32'h000153B7, 3'd4, 64'h0000000000000015, "b64_u");
      b_one(32'h800003B7, 3'd4, 64'hFFFFFFFFFFF80000, "b64_uneg");
      b_one(32'h03F00013, 3'd6, 64'h000000000000003F, "b64_shamt");
      b_one(32'hFF9FF06F, 3'd3, 64'hFFFFFFFFFFFFFFF8, "b64_j");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
